decode_stage: RTL and testbench

Instruction-register and decode stage directly downstream of the multi-cycle fetch/control block. Captures the 16-bit instruction word from memory on `IRWrite`, exposes the opcode and a generated immediate, and holds the architectural condition register (CR) and stack pointer (SP). Writes to these registers are driven by the control strobes `CRWrite`, `CRSrc` and `SPWrite`. Also evaluates the branch condition selected by `BType` and returns `BranchTaken` to the PC logic.

---
 rtl/decode_stage.sv | 149 ++++++++++++++
 tb/tb_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction register and decode stage behind the fetch/control block.
//
// Captures the instruction word on IRWrite and counts accepted instructions. Exposes the opcode
// and a generated immediate, and holds the condition register (CR) and stack pointer (SP). Also
// resolves the branch condition selected by BType.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN.
//   When defined, loading opcode 0xF sets a sticky Illegal flag and freezes IR/InstrCount.
//   When undefined, Illegal is tied to 0.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   IRWrite, MemData    instruction load strobe and memory read data
//   ALU1Result/2Result  ALU outputs (CR / SP sources)
//   CRWrite, CRSrc      CR load strobe and source select (ALU1, ALU2, MemData, Imm)
//   SPWrite             SP load strobe (source ALU2Result)
//   PCWriteCond, BType  branch resolve strobe and condition select
//   IR, Opcode, Imm     instruction register and decoded fields
//   CR, SP              architectural registers
//   BranchTaken         PCWriteCond AND selected condition
//   InstrCount          instructions accepted since reset (wraps)
//   Illegal             sticky illegal-opcode flag
module decode_stage #(
  parameter int unsigned           DATA_W   = 16,
  parameter logic [DATA_W-1:0]     SP_RESET = 16'hFFFE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IRWrite,
  input  logic [DATA_W-1:0] MemData,
  input  logic [DATA_W-1:0] ALU1Result,
  input  logic [DATA_W-1:0] ALU2Result,
  input  logic              CRWrite,
  input  logic [1:0]        CRSrc,
  input  logic              SPWrite,
  input  logic              PCWriteCond,
  input  logic [1:0]        BType,
  output logic [DATA_W-1:0] IR,
  output logic [3:0]        Opcode,
  output logic [DATA_W-1:0] Imm,
  output logic [DATA_W-1:0] CR,
  output logic [DATA_W-1:0] SP,
  output logic              BranchTaken,
  output logic [DATA_W-1:0] InstrCount,
  output logic              Illegal
);

  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] cr_q, cr_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              ir_load;
  logic              cond;
  logic [DATA_W-1:0] imm;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Once trapped, further instruction loads are ignored until reset.
  assign ir_load = IRWrite & ~illegal_q;

  always_comb begin
    illegal_d = illegal_q;
    if (ir_load && (MemData[15:12] == 4'hF)) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign Illegal = illegal_q;
`else
  assign ir_load = IRWrite;
  assign Illegal = 1'b0;
`endif

  // Immediate generation from the registered IR; class chosen by Opcode[3:2].
  always_comb begin
    imm = '0;
    unique case (ir_q[15:14])
      2'b00:   imm = {{4{ir_q[11]}}, ir_q[11:0]};
      2'b01:   imm = {8'h00, ir_q[7:0]};
      2'b10:   imm = {{3{ir_q[11]}}, ir_q[11:0], 1'b0};
      default: imm = '0;
    endcase
  end

  // Branch condition uses the registered CR, so a same-cycle CR write is not seen.
  always_comb begin
    cond = 1'b0;
    unique case (BType)
      2'b00:   cond = (cr_q == '0);
      2'b01:   cond = (cr_q != '0);
      2'b10:   cond = cr_q[DATA_W-1];
      default: cond = 1'b1;
    endcase
  end

  always_comb begin
    ir_d  = ir_q;
    cnt_d = cnt_q;
    cr_d  = cr_q;
    sp_d  = sp_q;
    if (ir_load) begin
      ir_d  = MemData;
      cnt_d = cnt_q + 1'b1;
    end
    if (CRWrite) begin
      unique case (CRSrc)
        2'b00:   cr_d = ALU1Result;
        2'b01:   cr_d = ALU2Result;
        2'b10:   cr_d = MemData;
        default: cr_d = imm; // immediate of the IR held before this edge
      endcase
    end
    if (SPWrite) begin
      sp_d = ALU2Result;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ir_q  <= '0;
      cr_q  <= '0;
      sp_q  <= SP_RESET;
      cnt_q <= '0;
    end else begin
      ir_q  <= ir_d;
      cr_q  <= cr_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  assign IR          = ir_q;
  assign Opcode      = ir_q[15:12];
  assign Imm         = imm;
  assign CR          = cr_q;
  assign SP          = sp_q;
  assign InstrCount  = cnt_q;
  assign BranchTaken = PCWriteCond & cond;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors, corner sequences and a randomized run
// against a behavioural model.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IRWrite;
  logic [15:0] MemData;
  logic [15:0] ALU1Result;
  logic [15:0] ALU2Result;
  logic        CRWrite;
  logic [1:0]  CRSrc;
  logic        SPWrite;
  logic        PCWriteCond;
  logic [1:0]  BType;
  logic [15:0] IR;
  logic [3:0]  Opcode;
  logic [15:0] Imm;
  logic [15:0] CR;
  logic [15:0] SP;
  logic        BranchTaken;
  logic [15:0] InstrCount;
  logic        Illegal;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned m_ir, m_cr, m_sp, m_cnt;
  bit          m_ill;

  decode_stage #(
    .DATA_W   (16),
    .SP_RESET (16'hFFFE)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IRWrite     (IRWrite),
    .MemData     (MemData),
    .ALU1Result  (ALU1Result),
    .ALU2Result  (ALU2Result),
    .CRWrite     (CRWrite),
    .CRSrc       (CRSrc),
    .SPWrite     (SPWrite),
    .PCWriteCond (PCWriteCond),
    .BType       (BType),
    .IR          (IR),
    .Opcode      (Opcode),
    .Imm         (Imm),
    .CR          (CR),
    .SP          (SP),
    .BranchTaken (BranchTaken),
    .InstrCount  (InstrCount),
    .Illegal     (Illegal)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Immediate from the instruction word, computed with signed integer arithmetic.
  function automatic int unsigned model_imm(input int unsigned ir);
    int v;
    case (ir / 4096 / 4)
      0: begin v = int'(ir % 4096); if (v >= 2048) v -= 4096; end
      1: v = int'(ir % 256);
      2: begin v = int'(ir % 4096); if (v >= 2048) v -= 4096; v = v * 2; end
      default: v = 0;
    endcase
    return int'(unsigned'(v)) & 32'hFFFF;
  endfunction

  function automatic bit model_bt(input bit pcwc, input int unsigned bt, input int unsigned cr);
    bit c;
    case (bt)
      0: c = (cr == 0);
      1: c = (cr != 0);
      2: c = (cr >= 32768);
      default: c = 1'b1;
    endcase
    return pcwc && c;
  endfunction

  function automatic bit trap_en();
`ifdef DECODE_ILLEGAL_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_ir = 0; m_cr = 0; m_sp = 16'hFFFE; m_cnt = 0; m_ill = 0;
  endtask

  // Advance the model by one edge using the inputs as currently driven.
  task automatic model_edge();
    int unsigned nir, ncr, nsp, ncnt;
    bit nill;
    nir = m_ir; ncr = m_cr; nsp = m_sp; ncnt = m_cnt; nill = m_ill;
    if (IRWrite && !(trap_en() && m_ill)) begin
      nir  = MemData;
      ncnt = (m_cnt + 1) % 65536;
      if (trap_en() && MemData / 4096 == 15) nill = 1;
    end
    if (CRWrite) begin
      case (CRSrc)
        0: ncr = ALU1Result;
        1: ncr = ALU2Result;
        2: ncr = MemData;
        default: ncr = model_imm(m_ir);
      endcase
    end
    if (SPWrite) nsp = ALU2Result;
    m_ir = nir; m_cr = ncr; m_sp = nsp; m_cnt = ncnt; m_ill = nill;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".IR"}, IR, m_ir);
    chk({tag, ".Opcode"}, Opcode, m_ir / 4096);
    chk({tag, ".Imm"}, Imm, model_imm(m_ir));
    chk({tag, ".CR"}, CR, m_cr);
    chk({tag, ".SP"}, SP, m_sp);
    chk({tag, ".InstrCount"}, InstrCount, m_cnt);
    chk({tag, ".Illegal"}, Illegal, m_ill);
  endtask

  task automatic idle();
    IRWrite = 0; CRWrite = 0; SPWrite = 0; PCWriteCond = 0;
    CRSrc = 0; BType = 0; MemData = 0; ALU1Result = 0; ALU2Result = 0;
  endtask

  // One clock edge; outputs are sampled 1 ns later.
  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [15:0] mem;
    logic [3:0]  op;
    logic [15:0] imm;
  } imm_vec_t;

  imm_vec_t vecs[4];

  initial begin
    vecs[0] = '{16'h1FFF, 4'h1, 16'hFFFF};
    vecs[1] = '{16'h58AB, 4'h5, 16'h00AB};
    vecs[2] = '{16'h9801, 4'h9, 16'hF002};
    vecs[3] = '{16'hC123, 4'hC, 16'h0000};

    idle();
    RST = 1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 0;
    #1;
    // Reset state
    chk("rst.IR", IR, 0);
    chk("rst.CR", CR, 0);
    chk("rst.SP", SP, 16'hFFFE);
    chk("rst.InstrCount", InstrCount, 0);
    chk("rst.Illegal", Illegal, 0);
    chk("rst.Imm", Imm, 0);
    PCWriteCond = 1; BType = 0;
    #1 chk("rst.BranchTaken", BranchTaken, 1);
    PCWriteCond = 0;

    // Immediate classes
    for (int i = 0; i < 4; i++) begin
      IRWrite = 1; MemData = vecs[i].mem;
      step();
      chk($sformatf("imm%0d.IR", i), IR, vecs[i].mem);
      chk($sformatf("imm%0d.Opcode", i), Opcode, vecs[i].op);
      chk($sformatf("imm%0d.Imm", i), Imm, vecs[i].imm);
    end
    IRWrite = 0;
    chk("imm.InstrCount", InstrCount, 4);

    // CR and branch conditions
    CRWrite = 1; CRSrc = 0; ALU1Result = 16'h8000;
    step();
    CRWrite = 0;
    chk("cr.load", CR, 16'h8000);
    PCWriteCond = 1;
    BType = 2; #1 chk("br.lt", BranchTaken, 1);
    BType = 0; #1 chk("br.eq", BranchTaken, 0);
    BType = 1; #1 chk("br.ne", BranchTaken, 1);
    BType = 3; #1 chk("br.always", BranchTaken, 1);
    PCWriteCond = 0;
    for (int b = 0; b < 4; b++) begin
      BType = 2'(b);
      #1 chk($sformatf("br.nocond%0d", b), BranchTaken, 0);
    end

    // Branch sees old CR while CR is being written
    PCWriteCond = 1; BType = 0; CRWrite = 1; CRSrc = 1; ALU2Result = 16'h0000;
    #1 chk("br.oldcr", BranchTaken, 0);
    step();
    chk("br.newcr", BranchTaken, 1);
    idle();

    // Simultaneous writes
    IRWrite = 1; MemData = 16'h1005;
    step();
    IRWrite = 1; MemData = 16'h4077; CRWrite = 1; CRSrc = 3; SPWrite = 1; ALU2Result = 16'hFFFC;
    step();
    idle();
    chk("sim.CR", CR, 16'h0005);
    chk("sim.IR", IR, 16'h4077);
    chk("sim.Imm", Imm, 16'h0077);
    chk("sim.SP", SP, 16'hFFFC);
    check_all("sim");

    // Asynchronous reset spanning an edge with strobes held
    IRWrite = 1; MemData = 16'h2222; CRWrite = 1; CRSrc = 0; ALU1Result = 16'h1234;
    SPWrite = 1; ALU2Result = 16'h0100;
    #1 RST = 1;
    model_reset();
    #2;
    check_all("arst.async");
    #7 RST = 0;  // edge passed while RST was high
    #1;
    check_all("arst.held");
    idle();

    // Illegal trap
    IRWrite = 1; MemData = 16'hF000;
    step();
    IRWrite = 1; MemData = 16'h1001;
    step();
    idle();
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill.IR", IR, 16'hF000);
    chk("ill.flag", Illegal, 1);
    chk("ill.cnt", InstrCount, 1);
`else
    chk("ill.IR", IR, 16'h1001);
    chk("ill.flag", Illegal, 0);
    chk("ill.cnt", InstrCount, 2);
`endif
    CRWrite = 1; CRSrc = 2; MemData = 16'hABCD; SPWrite = 1; ALU2Result = 16'h7777;
    step();
    idle();
    check_all("ill.crsp");

    // Randomized run against the model
    RST = 1; #1 RST = 0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      IRWrite     = 1'($urandom);
      MemData     = {4'($urandom_range(0, 14)), 12'($urandom)};
      if ($urandom_range(0, 7) == 0) MemData[11:0] = '0;
      ALU1Result  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      ALU2Result  = 16'($urandom);
      CRWrite     = 1'($urandom);
      CRSrc       = 2'($urandom);
      SPWrite     = 1'($urandom);
      PCWriteCond = 1'($urandom);
      BType       = 2'($urandom);
      #1 chk($sformatf("rnd%0d.BranchTaken", n), BranchTaken,
             model_bt(PCWriteCond, BType, m_cr));
      step();
      check_all($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
